// File: rtl/tone_arb_pkg.sv
// tone_arb_pkg: state encoding, timing defaults, note periods and the priority pick
// shared by the tone arbiter and the tone sources.
package tone_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int CLK_FREQ       = 50_000_000;
    localparam int GAP_CYCLES_DEF = 50_000;
    localparam int MAX_REQ        = 32;

    // Note periods in clk cycles: CLK_FREQ / note frequency in Hz.
    localparam int NOTE_M1 = CLK_FREQ / 262;
    localparam int NOTE_M2 = CLK_FREQ / 294;
    localparam int NOTE_M3 = CLK_FREQ / 330;
    localparam int NOTE_M4 = CLK_FREQ / 349;
    localparam int NOTE_M5 = CLK_FREQ / 392;
    localparam int NOTE_M6 = CLK_FREQ / 440;
    localparam int NOTE_M7 = CLK_FREQ / 494;
    localparam int NOTE_H1 = CLK_FREQ / 523;

    // One-hot of the lowest set bit; index 0 is the highest priority.
    function automatic logic [MAX_REQ-1:0] lowest_set(input logic [MAX_REQ-1:0] r);
        return r & (~r + MAX_REQ'(1));
    endfunction

endpackage

// File: rtl/tone_timer.sv
// tone_timer: up-counter that latches a length on start and flags its last cycle;
// expire is high during the final counted cycle so the owner can act on the next edge.
module tone_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d, lim_q, lim_d;
    logic         act_q, act_d;

    assign expire = act_q && (cnt_q == lim_q - W'(1));

    always_comb begin
        cnt_d = start ? '0 : (act_q ? cnt_q + W'(1) : cnt_q);
        lim_d = start ? load_val : lim_q;
        act_d = start | (act_q & ~stop & ~expire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            lim_q <= '0;
            act_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
            act_q <= act_d;
        end
    end

endmodule

// File: rtl/tone_arbiter.sv
// tone_arbiter: fixed-priority owner of the buzzer tone channel; times each granted
// tone, handles preemption/cancel, and inserts a silent gap after every grant.
module tone_arbiter
    import tone_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int PERIOD_W   = 20,
    parameter int DUR_W      = 32,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*PERIOD_W-1:0] req_period,
    input  logic [NUM_REQ*DUR_W-1:0]    req_dur,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          aborted,
    output logic                        tone_en,
    output logic [PERIOD_W-1:0]         tone_period,
    output logic                        busy
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d, done_q, done_d, aborted_q, aborted_d;
    logic                  tone_en_q, tone_en_d, busy_q, busy_d;
    logic [PERIOD_W-1:0]   tone_period_q, tone_period_d, sel_period;
    logic [DUR_W-1:0]      sel_dur;
    logic [NUM_REQ-1:0]    win_oh;
    logic                  dur_start, dur_stop, dur_exp, gap_start, gap_exp, preempt, cancel;

    assign win_oh  = NUM_REQ'(lowest_set(MAX_REQ'(req)));
    // grant_q - 1 masks every index above the one-hot owner in priority
    assign preempt = |(req & (grant_q - NUM_REQ'(1)));
    assign cancel  = ~|(req & grant_q);

    always_comb begin
        sel_period = '0;
        sel_dur    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_period = req_period[i*PERIOD_W +: PERIOD_W];
                sel_dur    = req_dur[i*DUR_W +: DUR_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        done_d        = '0;
        aborted_d     = '0;
        tone_en_d     = tone_en_q;
        tone_period_d = tone_period_q;
        busy_d        = busy_q;
        dur_start     = 1'b0;
        dur_stop      = 1'b0;
        gap_start     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req && sel_dur == '0) begin
                    done_d = win_oh;
                end else if (|req) begin
                    state_d       = ST_PLAY;
                    grant_d       = win_oh;
                    tone_en_d     = |sel_period;
                    tone_period_d = sel_period;
                    busy_d        = 1'b1;
                    dur_start     = 1'b1;
                end
            end
            ST_PLAY: begin
                // completion outranks a preempt/cancel landing on the same cycle
                if (dur_exp || preempt || cancel) begin
                    state_d       = ST_GAP;
                    done_d        = dur_exp ? grant_q : '0;
                    aborted_d     = dur_exp ? '0 : grant_q;
                    grant_d       = '0;
                    tone_en_d     = 1'b0;
                    tone_period_d = '0;
                    dur_stop      = 1'b1;
                    gap_start     = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_exp) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            done_q        <= '0;
            aborted_q     <= '0;
            tone_en_q     <= 1'b0;
            tone_period_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            tone_en_q     <= tone_en_d;
            tone_period_q <= tone_period_d;
            busy_q        <= busy_d;
        end
    end

    tone_timer #(.W(DUR_W)) u_dur (
        .clk      (clk),
        .rst      (rst),
        .start    (dur_start),
        .stop     (dur_stop),
        .load_val (sel_dur),
        .expire   (dur_exp)
    );

    tone_timer #(.W(GW)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .start    (gap_start),
        .stop     (1'b0),
        .load_val (GW'(GAP_CYCLES)),
        .expire   (gap_exp)
    );

    assign grant       = grant_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign tone_en     = tone_en_q;
    assign tone_period = tone_period_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// tb_tone_arbiter: directed scenarios with hand-computed cycle-exact expectations,
// GAP_CYCLES=4; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_tone_arbiter;

    localparam int N  = 3;
    localparam int PW = 20;
    localparam int DW = 32;

    logic            clk, rst;
    logic [N-1:0]    req;
    logic [N*PW-1:0] req_period;
    logic [N*DW-1:0] req_dur;
    logic [N-1:0]    grant, done, aborted;
    logic            tone_en, busy;
    logic [PW-1:0]   tone_period;

    int vec, miss;

    tone_arbiter #(.NUM_REQ(N), .PERIOD_W(PW), .DUR_W(DW), .GAP_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_period  (req_period),
        .req_dur     (req_dur),
        .grant       (grant),
        .done        (done),
        .aborted     (aborted),
        .tone_en     (tone_en),
        .tone_period (tone_period),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tone(input int i, input logic [PW-1:0] p, input logic [DW-1:0] d);
        req_period[i*PW +: PW] = p;
        req_dur[i*DW +: DW]    = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_period = '0; req_dur = '0;
        #2 rst = 1'b0;
        tick();
        vec++; if (grant !== 3'b000) begin miss++; $display("FAIL reset_grant: got %b want 000", grant); end
        vec++; if (done !== 3'b000 || aborted !== 3'b000) begin miss++; $display("FAIL reset_pulses: got done=%b aborted=%b want 000/000", done, aborted); end
        vec++; if (tone_en !== 1'b0 || busy !== 1'b0 || tone_period !== '0) begin miss++; $display("FAIL reset_tone: got en=%b busy=%b period=%0d want 0/0/0", tone_en, busy, tone_period); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int hi;
        set_tone(2, 20'd1000, 32'd10);
        req = 3'b100;
        tick();
        vec++; if (grant !== 3'b100 || tone_en !== 1'b1) begin miss++; $display("FAIL single_latency: got grant=%b en=%b want 100/1", grant, tone_en); end
        vec++; if (tone_period !== 20'd1000) begin miss++; $display("FAIL single_period: got %0d want 1000", tone_period); end
        hi = 0;
        repeat (10) begin if (tone_en) hi++; tick(); end
        vec++; if (hi !== 10) begin miss++; $display("FAIL single_length: got %0d cycles want 10", hi); end
        vec++; if (done !== 3'b100 || tone_en !== 1'b0 || grant !== 3'b000) begin miss++; $display("FAIL single_done: got done=%b en=%b grant=%b want 100/0/000", done, tone_en, grant); end
        req = 3'b000;
        tick();
        vec++; if (done !== 3'b000) begin miss++; $display("FAIL single_done_once: got %b want 000", done); end
        repeat (2) tick();
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL single_gap_busy: got %b want 1", busy); end
        tick();
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL single_gap_end: got busy=%b want 0", busy); end
    endtask

    task automatic test_preempt();
        int hi;
        set_tone(2, 20'd3000, 32'd100);
        req = 3'b100;
        tick();
        repeat (20) tick();
        set_tone(0, 20'd500, 32'd5);
        req = 3'b101;
        tick();
        vec++; if (aborted !== 3'b100 || done !== 3'b000) begin miss++; $display("FAIL preempt_abort: got aborted=%b done=%b want 100/000", aborted, done); end
        vec++; if (tone_en !== 1'b0 || grant !== 3'b000 || busy !== 1'b1) begin miss++; $display("FAIL preempt_gap: got en=%b grant=%b busy=%b want 0/000/1", tone_en, grant, busy); end
        req = 3'b001;
        repeat (4) tick();
        vec++; if (grant !== 3'b000 || busy !== 1'b0) begin miss++; $display("FAIL preempt_idle: got grant=%b busy=%b want 000/0", grant, busy); end
        tick();
        vec++; if (grant !== 3'b001 || tone_period !== 20'd500 || tone_en !== 1'b1) begin miss++; $display("FAIL preempt_regrant: got grant=%b period=%0d en=%b want 001/500/1", grant, tone_period, tone_en); end
        hi = 0;
        repeat (5) begin if (tone_en) hi++; tick(); end
        vec++; if (hi !== 5 || done !== 3'b001) begin miss++; $display("FAIL preempt_done: got len=%0d done=%b want 5/001", hi, done); end
        req = 3'b000;
        repeat (4) tick();
    endtask

    task automatic test_rest();
        int g, en;
        set_tone(1, 20'd0, 32'd8);
        req = 3'b010;
        tick();
        g = 0; en = 0;
        repeat (8) begin if (grant == 3'b010) g++; if (tone_en) en++; tick(); end
        vec++; if (g !== 8 || en !== 0) begin miss++; $display("FAIL rest_play: got grant_cycles=%0d en_cycles=%0d want 8/0", g, en); end
        vec++; if (done !== 3'b010) begin miss++; $display("FAIL rest_done: got %b want 010", done); end
        req = 3'b000;
        repeat (4) tick();
        set_tone(1, 20'd0, 32'd0);
        req = 3'b010;
        tick();
        vec++; if (done !== 3'b010 || busy !== 1'b0 || grant !== 3'b000) begin miss++; $display("FAIL zero_dur: got done=%b busy=%b grant=%b want 010/0/000", done, busy, grant); end
        req = 3'b000;
        tick();
        vec++; if (done !== 3'b000 || busy !== 1'b0) begin miss++; $display("FAIL zero_dur_after: got done=%b busy=%b want 000/0", done, busy); end
    endtask

    task automatic test_boundary();
        set_tone(1, 20'd700, 32'd6);
        req = 3'b010;
        tick();
        repeat (5) tick();
        req = 3'b000;
        tick();
        vec++; if (done !== 3'b010 || aborted !== 3'b000) begin miss++; $display("FAIL boundary_conflict: got done=%b aborted=%b want 010/000", done, aborted); end
        req = 3'b010;
        repeat (4) tick();
        vec++; if (grant !== 3'b000 || busy !== 1'b0) begin miss++; $display("FAIL boundary_gap: got grant=%b busy=%b want 000/0", grant, busy); end
        tick();
        vec++; if (grant !== 3'b010 || tone_period !== 20'd700) begin miss++; $display("FAIL boundary_repeat: got grant=%b period=%0d want 010/700", grant, tone_period); end
        req = 3'b000;
        tick();
        vec++; if (aborted !== 3'b010 || done !== 3'b000) begin miss++; $display("FAIL cancel_abort: got aborted=%b done=%b want 010/000", aborted, done); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        set_tone(1, 20'd900, 32'd50);
        req = 3'b010;
        tick();
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        vec++; if (tone_en !== 1'b0 || grant !== 3'b000 || busy !== 1'b0) begin miss++; $display("FAIL reset_async: got en=%b grant=%b busy=%b want 0/000/0", tone_en, grant, busy); end
        tick();
        rst = 1'b1;
        tick();
        vec++; if (grant !== 3'b010 || tone_en !== 1'b1) begin miss++; $display("FAIL reset_regrant: got grant=%b en=%b want 010/1", grant, tone_en); end
        req = 3'b000;
        tick();
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        set_tone(0, 20'd100, 32'd3);
        set_tone(1, 20'd200, 32'd3);
        set_tone(2, 20'd300, 32'd3);
        req = 3'b111;
        tick();
        vec++; if (grant !== 3'b001 || tone_period !== 20'd100) begin miss++; $display("FAIL b2b_first: got grant=%b period=%0d want 001/100", grant, tone_period); end
        repeat (3) tick();
        vec++; if (done !== 3'b001) begin miss++; $display("FAIL b2b_done0: got %b want 001", done); end
        req = 3'b110;
        repeat (5) tick();
        vec++; if (grant !== 3'b010 || tone_period !== 20'd200) begin miss++; $display("FAIL b2b_second: got grant=%b period=%0d want 010/200", grant, tone_period); end
        repeat (3) tick();
        vec++; if (done !== 3'b010) begin miss++; $display("FAIL b2b_done1: got %b want 010", done); end
        req = 3'b100;
        repeat (5) tick();
        vec++; if (grant !== 3'b100 || tone_period !== 20'd300) begin miss++; $display("FAIL b2b_third: got grant=%b period=%0d want 100/300", grant, tone_period); end
        repeat (3) tick();
        vec++; if (done !== 3'b100) begin miss++; $display("FAIL b2b_done2: got %b want 100", done); end
        req = 3'b000;
        repeat (4) tick();
    endtask

    initial begin
        vec = 0;
        miss = 0;
        test_reset();
        test_single();
        test_preempt();
        test_rest();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
